// File: rtl/sb_pkg.sv
// sb_pkg: shared types and default sizing for the store buffer.
//   SB_DEPTH / SB_AW / SB_DW : default entry count, address width, data width.
//   sb_entry_t               : one buffered store {adr, wd} at default widths.
package sb_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_AW    = 32;
    localparam int unsigned SB_DW    = 32;

    typedef struct packed {
        logic [SB_AW-1:0] adr;
        logic [SB_DW-1:0] wd;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: youngest-match search over the valid store-buffer entries.
// Used only when STORE_BUF_FWD_EN is defined.
//   adr, wd   in  : entry storage, indexed by physical slot
//   head      in  : slot of the oldest entry
//   count     in  : number of valid entries
//   load_adr  in  : load byte address (compared at word granularity)
//   hit       out : some valid entry matches load_adr
//   data      out : data of the youngest matching entry
module sb_fwd_match import sb_pkg::*; #(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW,
    parameter int unsigned PW    = $clog2(DEPTH),
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic [AW-1:0] adr [DEPTH],
    input  logic [DW-1:0] wd  [DEPTH],
    input  logic [PW-1:0] head,
    input  logic [CW-1:0] count,
    input  logic [AW-1:0] load_adr,
    output logic          hit,
    output logic [DW-1:0] data
);

    logic [PW-1:0] idx;

    // Walk oldest -> youngest; a later match overwrites, so the youngest wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count) && (adr[idx][AW-1:2] == load_adr[AW-1:2])) begin
                hit  = 1'b1;
                data = wd[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order circular FIFO of core stores draining to data memory.
// Optional store-to-load forwarding is enabled by defining STORE_BUF_FWD_EN.
//   clk, reset       in  : clock, asynchronous active-high reset
//   MemWrite         in  : core store request
//   DataAdr/WriteData in : store address / data
//   Stall            out : buffer full while a store is requested
//   mem_we/mem_adr/mem_wd out : head entry toward memory
//   mem_ready        in  : memory accepts the head entry this cycle
//   Empty, Count     out : occupancy
//   LoadAdr in, LoadHit/LoadData out : forwarding port (STORE_BUF_FWD_EN only)
module store_buffer import sb_pkg::*; #(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemWrite,
    input  logic [AW-1:0]              DataAdr,
    input  logic [DW-1:0]              WriteData,
    output logic                       Stall,
    output logic                       mem_we,
    output logic [AW-1:0]              mem_adr,
    output logic [DW-1:0]              mem_wd,
    input  logic                       mem_ready,
`ifdef STORE_BUF_FWD_EN
    input  logic [AW-1:0]              LoadAdr,
    output logic                       LoadHit,
    output logic [DW-1:0]              LoadData,
`endif
    output logic                       Empty,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] adr_q [DEPTH];
    logic [DW-1:0] wd_q  [DEPTH];

    logic full;
    logic enq;
    logic deq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Full blocks enqueue even if the head drains this cycle (no full bypass).
    assign full = (count_q == CW'(DEPTH));
    assign enq  = MemWrite & ~full;
    assign deq  = (count_q != '0) & mem_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (enq) begin
            adr_q[wr_ptr_q] <= DataAdr;
            wd_q[wr_ptr_q]  <= WriteData;
        end
    end

    assign Stall   = MemWrite & full;
    assign mem_we  = (count_q != '0);
    assign mem_adr = adr_q[rd_ptr_q];
    assign mem_wd  = wd_q[rd_ptr_q];
    assign Empty   = (count_q == '0);
    assign Count   = count_q;

`ifdef STORE_BUF_FWD_EN
    sb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .PW    (PW),
        .CW    (CW)
    ) u_fwd_match (
        .adr      (adr_q),
        .wd       (wd_q),
        .head     (rd_ptr_q),
        .count    (count_q),
        .load_adr (LoadAdr),
        .hit      (LoadHit),
        .data     (LoadData)
    );
`endif

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores (power of two, >=2).
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 MemWrite  in  1  core store request.
REQ-007 DataAdr  in  AW  store byte address from core.
REQ-008 WriteData  in  DW  store data from core.
REQ-009 Stall  out  1  core must hold its store; asserted when MemWrite and buffer full.
REQ-010 mem_we  out  1  store valid toward data memory.
REQ-011 mem_adr  out  AW  head-entry address.
REQ-012 mem_wd  out  DW  head-entry data.
REQ-013 mem_ready  in  1  data memory accepts head entry this cycle.
REQ-014 Empty  out  1  no entries held.
REQ-015 Count  out  $clog2(DEPTH+1)  entries held.

Function
REQ-016 Circular FIFO: write pointer, read pointer, count; pointers wrap DEPTH-1 -> 0.
REQ-017 Enqueue on clock edge when MemWrite=1 and Count<DEPTH; entry = {DataAdr, WriteData}.
REQ-018 Stall = MemWrite & (Count==DEPTH), combinational; no enqueue while stalled; a pop in the same cycle does not clear Stall (no full-bypass).
REQ-019 mem_we = (Count!=0); mem_adr/mem_wd driven from head entry, stable while mem_we=1 and mem_ready=0.
REQ-020 Dequeue on clock edge when mem_we=1 and mem_ready=1; mem_ready ignored when Empty.
REQ-021 Latency: store enqueued at edge N presents mem_we=1 in cycle after edge N when buffer was empty; no combinational bypass input->mem port.
REQ-022 Simultaneous enqueue and dequeue (not full): both pointers advance, Count unchanged.
REQ-023 Stores drain strictly in program order; repeated addresses are kept as separate entries (no merging).
REQ-024 Empty = (Count==0).

Reset
REQ-025 reset=1 asynchronously clears pointers and Count; Stall=0, mem_we=0, Empty=1, Count=0.
REQ-026 Reset mid-drain discards all pending stores; entry storage contents need not be cleared.
REQ-027 First enqueue possible on first rising edge after reset deasserts.

Configuration
REQ-028 Macro STORE_BUF_FWD_EN adds ports LoadAdr (in, AW), LoadHit (out, 1), LoadData (out, DW).
REQ-029 With STORE_BUF_FWD_EN: LoadHit=1 when any valid entry's address[AW-1:2] equals LoadAdr[AW-1:2]; LoadData = youngest matching entry; combinational; LoadHit=0 when Empty.
REQ-030 Without STORE_BUF_FWD_EN: ports absent, no compare logic synthesized.

Structure
REQ-031 Shared package sb_pkg: sb_entry_t struct {adr, wd}, default DEPTH/AW/DW constants.
REQ-032 One sub-module sb_fwd_match (priority youngest-match search), instantiated only under STORE_BUF_FWD_EN.

Verification
REQ-033 Reset 22 ns, then MemWrite with DataAdr=100, WriteData=25, mem_ready=1 -> next cycle mem_we=1, mem_adr=100, mem_wd=25; following cycle Empty=1.
REQ-034 mem_ready=0, stores to 96,100,104,108 -> Count=4, Stall=0; fifth store to 112 -> Stall=1, Count stays 4; raise mem_ready -> drain order 96,100,104,108, then 112 enqueued.
REQ-035 Count=2, MemWrite=1 and mem_ready=1 same cycle -> Count stays 2, head advances by one entry.
REQ-036 Count=3, assert reset between edges -> mem_we=0, Empty=1 immediately, before next edge; no stale store issued afterwards.
REQ-037 Pointer wrap: 10 store/drain pairs at DEPTH=4 -> all 10 appear on mem port in order with correct data.
REQ-038 With STORE_BUF_FWD_EN: stores (100,25) then (100,7) held, LoadAdr=102 -> LoadHit=1, LoadData=7; LoadAdr=96 -> LoadHit=0.
